hazard_sb: RTL and testbench
============================

Name: hazard_sb

Overview:
- Parametrised successor of the pipeline hazard unit for the 5-stage MIPS core.
- Provides D/E forwarding selects, load-use and branch/jr stalls, exception flush and redirect, and a global memory-wait freeze.
- Adds a HI/LO scoreboard so mult/div runs in the background; the pipeline stalls only when a later instruction actually needs HI/LO.
- Adds a divider watchdog and a saturating stall-cycle counter.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero and never matches.
EXC_VEC, 32'hbfc00380, exception entry PC.
MD_TIMEOUT, 64, busy cycles before md_timeout is set.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_stall  in  1  I/D memory wait; freezes whole pipeline
rsD, rtD  in  REG_AW  decode sources
branchD, jrD  in  1  branch; jr/jalr (jrD covers both)
hiloreadD  in  1  mfhi/mflo in D
muldivD  in  1  mult/div/mthi/mtlo in D
rsE, rtE, writeregE  in  REG_AW  execute regs
regwriteE, memtoregE  in  1  execute controls
muldiv_startE  in  1  mult/div issuing in E
muldiv_done  in  1  HI/LO result written this cycle
writeregM  in  REG_AW  mem dest
regwriteM, memtoregM  in  1  mem controls
excepttypeM  in  32  exception code from M
epcM  in  32  CP0 EPC
writeregW  in  REG_AW  writeback dest
regwriteW  in  1  writeback write enable
forwardaD, forwardbD  out  1  forward ALU result from M to D comparator
forwardaE, forwardbE  out  2  10 = M, 01 = W, 00 = register file
stallF, stallD, stallE, stallM, stallW  out  1  stage holds
flushF, flushD, flushE, flushM, flushW  out  1  stage clears
newpcF  out  32  redirect PC
muldiv_cancel  out  1  abort in-flight mult/div
hilo_busy  out  1  scoreboard bit (registered)
md_timeout  out  1  sticky watchdog flag
stall_cnt  out  CNT_W  saturating count of cycles with stallD = 1

Behaviour:

Register matching:
- Every register compare requires a nonzero address.
- All forwarding rules follow this; M has priority over W.

Decode-stage stall terms:
- lw = memtoregE & (writeregE == rsD | writeregE == rtD).
- br = (branchD | jrD) & (regwriteE & writeregE ∈ {rsD, rtD} | memtoregM & writeregM ∈ {rsD, rtD}).
- For jrD, only rsD is compared.
- hl = (hiloreadD | muldivD) & (hilo_busy | muldiv_startE).

Exception handling:
- exc = (excepttypeM != 0) & ~mem_stall.
- newpcF = EXC_VEC for codes 0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc, 0xd; epcM for 0xe; 0 otherwise. Combinational.

Priority:
1. mem_stall: all stalls = 1 and all flushes = 0, except that exc is held off until mem_stall drops.
2. exc: all flushes = 1 and all stalls = 0.
3. Otherwise:
   - stallF = stallD = lw | br | hl.
   - flushE = lw | br | hl.
   - stallE, stallM, stallW, flushF, flushD, flushM and flushW are all 0.

Scoreboard FSM (IDLE, BUSY):
- IDLE → BUSY on muldiv_startE & ~stallE & ~flushE.
- BUSY → IDLE on muldiv_done.
- If done and start occur in the same cycle, stay in BUSY.
- A start is accepted only from IDLE or with done; the hl stall guarantees this.
- hilo_busy = (state == BUSY).

Cancel:
- If exc occurs while in BUSY, or while muldiv_startE is asserted, muldiv_cancel = 1 in that cycle (combinational).
- The next state is IDLE.

Watchdog:
- Counter clears in IDLE and increments in BUSY.
- When it reaches MD_TIMEOUT, md_timeout is set.
- md_timeout is cleared only by rst.

stall_cnt:
- Increments when stallD = 1 and saturates at all-ones.
- Counts mem_stall cycles too.

Reset (synchronous):
- state = IDLE, hilo_busy = 0, md_timeout = 0, stall_cnt = 0.
- Combinational outputs follow their inputs.
- rst asserted mid-BUSY returns to IDLE next cycle without pulsing muldiv_cancel.

Decomposition:
- Package hazard_pkg holds:
  - exception code localparams (EXC_INT = 1, ADEL = 4, ADES = 5, SYS = 8, BP = 9, RI = a, OV = c, TR = d, ERET = e);
  - EXC_VEC default;
  - FSM state encoding.
- Sub-module muldiv_scoreboard contains the FSM, watchdog and cancel logic.
- The top level holds forwarding, stall/flush priority and stall_cnt.

Test Plan:
1. Load-use: lw writeregE = 8 in E, rsD = 8 → stallF = stallD = flushE = 1 for 1 cycle; next cycle forwardaE = 01 when the add reaches E.
2. Background div: muldiv_startE = 1 with no stalls → hilo_busy = 1 next cycle. Independent adds flow with no stall. hiloreadD = 1 → stallD = 1 until muldiv_done; hilo_busy = 0 the cycle after done, and mfhi proceeds.
3. Exception mid-div: BUSY, excepttypeM = 0xc → muldiv_cancel = 1, all flushes = 1, newpcF = bfc00380; next cycle hilo_busy = 0.
4. ERET under mem_stall: excepttypeM = 0xe, epcM = 0x80001234, mem_stall = 1 for 3 cycles → all stalls = 1 and flushes = 0; the cycle mem_stall drops, all flushes = 1 and newpcF = 80001234.
5. Watchdog: start, no done for 64 cycles → md_timeout = 1 and stays 1 after done; rst → 0.
6. Reg-0 and priority: writeregM = writeregW = 0 with rsE = 0 → forwardaE = 00. rsE = 5 with M and W both writing r5 → forwardaE = 10.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: exception codes, redirect vector,
// scoreboard state encoding and the exception redirect-target helper.
package hazard_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] EXC_VEC_DEF = 32'hbfc0_0380;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_t;

  // Real exceptions enter the vector, eret returns to EPC, anything else is 0.
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR:
        exc_target = vec;
      EXC_ERET:
        exc_target = epc;
      default:
        exc_target = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_scoreboard.sv
// HI/LO scoreboard: tracks a background mult/div, aborts it on an exception
// and raises a sticky flag when the unit stays busy too long.
module muldiv_scoreboard
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_done,
  input  logic i_stallE,
  input  logic i_flushE,
  input  logic i_exc,
  output logic o_busy,
  output logic o_cancel,
  output logic o_timeout
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MD_TIMEOUT);

  sb_state_t       r_state;
  sb_state_t       w_next;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_accept;

  assign w_accept = i_start & ~i_stallE & ~i_flushE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= SB_IDLE;
    else     r_state <= w_next;
  end

  // An exception kills both the in-flight op and one trying to issue.
  always_comb begin
    w_next = r_state;
    if (i_exc)
      w_next = SB_IDLE;
    else if (w_accept)
      w_next = SB_BUSY;
    else if (r_state == SB_BUSY && i_done)
      w_next = SB_IDLE;
  end

  always_comb begin
    o_busy   = (r_state == SB_BUSY);
    o_cancel = ~rst & i_exc & ((r_state == SB_BUSY) | i_start);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == SB_IDLE)
        r_wd <= '0;
      else if (r_wd != WD_MAX)
        r_wd <= r_wd + WD_W'(1);
      if (r_state == SB_BUSY && r_wd == WD_MAX - WD_W'(1))
        r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard unit for the 5-stage MIPS core: forwarding, stalls,
// exception flush/redirect, memory freeze and HI/LO scoreboard.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int          REG_AW     = 5,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter int          MD_TIMEOUT = 64,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_stall,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              hiloreadD,
  input  logic              muldivD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              muldiv_startE,
  input  logic              muldiv_done,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [31:0]       excepttypeM,
  input  logic [31:0]       epcM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [31:0]       newpcF,
  output logic              muldiv_cancel,
  output logic              hilo_busy,
  output logic              md_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             w_lw;
  logic             w_br;
  logic             w_hl;
  logic             w_exc;
  logic             w_hazard;
  logic             w_brsrcE;
  logic             w_brsrcM;
  logic [CNT_W-1:0] r_stall_cnt;

  // r0 is hardwired zero, so it never creates a dependency.
  function automatic logic rmatch(input logic [REG_AW-1:0] a,
                                  input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    forwardaD = regwriteM & rmatch(rsD, writeregM);
    forwardbD = regwriteM & rmatch(rtD, writeregM);
    if (regwriteM && rmatch(rsE, writeregM))      forwardaE = 2'b10;
    else if (regwriteW && rmatch(rsE, writeregW)) forwardaE = 2'b01;
    else                                          forwardaE = 2'b00;
    if (regwriteM && rmatch(rtE, writeregM))      forwardbE = 2'b10;
    else if (regwriteW && rmatch(rtE, writeregW)) forwardbE = 2'b01;
    else                                          forwardbE = 2'b00;
  end

  // jr/jalr only read rs; a plain branch compares both sources.
  always_comb begin
    w_brsrcE = rmatch(writeregE, rsD) | (~jrD & rmatch(writeregE, rtD));
    w_brsrcM = rmatch(writeregM, rsD) | (~jrD & rmatch(writeregM, rtD));
    w_lw     = memtoregE & (rmatch(writeregE, rsD) | rmatch(writeregE, rtD));
    w_br     = (branchD | jrD) & ((regwriteE & w_brsrcE) | (memtoregM & w_brsrcM));
    w_hl     = (hiloreadD | muldivD) & (hilo_busy | muldiv_startE);
    w_hazard = w_lw | w_br | w_hl;
    w_exc    = (excepttypeM != 32'h0) & ~mem_stall;
  end

  // Memory wait wins outright; a pending exception waits for it to clear.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    stallW = 1'b0;
    flushF = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (w_exc) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = w_hazard;
      stallD = w_hazard;
      flushE = w_hazard;
    end
  end

  assign newpcF = exc_target(excepttypeM, epcM, EXC_VEC);

  muldiv_scoreboard #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_start   (muldiv_startE),
    .i_done    (muldiv_done),
    .i_stallE  (stallE),
    .i_flushE  (flushE),
    .i_exc     (w_exc),
    .o_busy    (hilo_busy),
    .o_cancel  (muldiv_cancel),
    .o_timeout (md_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (stallD && r_stall_cnt != '1)
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_sb;

  localparam int AW      = 5;
  localparam int MDT     = 64;
  localparam int CW      = 6;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_stall;
  logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic          branchD, jrD, hiloreadD, muldivD;
  logic          regwriteE, memtoregE, muldiv_startE, muldiv_done;
  logic          regwriteM, memtoregM, regwriteW;
  logic [31:0]   excepttypeM, epcM;
  logic          forwardaD, forwardbD;
  logic [1:0]    forwardaE, forwardbE;
  logic          stallF, stallD, stallE, stallM, stallW;
  logic          flushF, flushD, flushE, flushM, flushW;
  logic [31:0]   newpcF;
  logic          muldiv_cancel, hilo_busy, md_timeout;
  logic [CW-1:0] stall_cnt;

  hazard_sb #(
    .REG_AW     (AW),
    .EXC_VEC    (32'hbfc00380),
    .MD_TIMEOUT (MDT),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (mem_stall),
    .rsD           (rsD),
    .rtD           (rtD),
    .branchD       (branchD),
    .jrD           (jrD),
    .hiloreadD     (hiloreadD),
    .muldivD       (muldivD),
    .rsE           (rsE),
    .rtE           (rtE),
    .writeregE     (writeregE),
    .regwriteE     (regwriteE),
    .memtoregE     (memtoregE),
    .muldiv_startE (muldiv_startE),
    .muldiv_done   (muldiv_done),
    .writeregM     (writeregM),
    .regwriteM     (regwriteM),
    .memtoregM     (memtoregM),
    .excepttypeM   (excepttypeM),
    .epcM          (epcM),
    .writeregW     (writeregW),
    .regwriteW     (regwriteW),
    .forwardaD     (forwardaD),
    .forwardbD     (forwardbD),
    .forwardaE     (forwardaE),
    .forwardbE     (forwardbE),
    .stallF        (stallF),
    .stallD        (stallD),
    .stallE        (stallE),
    .stallM        (stallM),
    .stallW        (stallW),
    .flushF        (flushF),
    .flushD        (flushD),
    .flushE        (flushE),
    .flushM        (flushM),
    .flushW        (flushW),
    .newpcF        (newpcF),
    .muldiv_cancel (muldiv_cancel),
    .hilo_busy     (hilo_busy),
    .md_timeout    (md_timeout),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: is a mult/div outstanding, how long, and stall history.
  bit m_busy, m_to;
  int m_wd, m_scnt;

  bit         e_exc, e_fwdaD, e_fwdbD, e_cancel;
  bit [1:0]   e_fwdaE, e_fwdbE;
  bit         e_stF, e_stD, e_stE, e_stM, e_stW;
  bit         e_flF, e_flD, e_flE, e_flM, e_flW;
  bit [31:0]  e_newpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit dep(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic bit [1:0] fwd_e(input logic [AW-1:0] src);
    if (regwriteM && dep(src, writeregM)) return 2'b10;
    if (regwriteW && dep(src, writeregW)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit lw, br, hl, need, srcE, srcM;
    lw   = memtoregE && (dep(writeregE, rsD) || dep(writeregE, rtD));
    srcE = dep(writeregE, rsD) || (!jrD && dep(writeregE, rtD));
    srcM = dep(writeregM, rsD) || (!jrD && dep(writeregM, rtD));
    br   = (branchD || jrD) && ((regwriteE && srcE) || (memtoregM && srcM));
    hl   = (hiloreadD || muldivD) && (m_busy || muldiv_startE);
    need = lw || br || hl;
    e_exc = (excepttypeM != 0) && !mem_stall;
    {e_stF, e_stD, e_stE, e_stM, e_stW} = '0;
    {e_flF, e_flD, e_flE, e_flM, e_flW} = '0;
    if (mem_stall)  {e_stF, e_stD, e_stE, e_stM, e_stW} = 5'b11111;
    else if (e_exc) {e_flF, e_flD, e_flE, e_flM, e_flW} = 5'b11111;
    else begin
      e_stF = need; e_stD = need; e_flE = need;
    end
    e_fwdaD  = regwriteM && dep(rsD, writeregM);
    e_fwdbD  = regwriteM && dep(rtD, writeregM);
    e_fwdaE  = fwd_e(rsE);
    e_fwdbE  = fwd_e(rtE);
    e_cancel = !rst && e_exc && (m_busy || muldiv_startE);
    case (excepttypeM)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd: e_newpc = 32'hbfc00380;
      32'he:   e_newpc = epcM;
      default: e_newpc = 32'h0;
    endcase
  endtask

  task automatic model_update();
    model_comb();
    if (rst) begin
      m_busy = 0; m_to = 0; m_wd = 0; m_scnt = 0;
    end else begin
      if (m_busy) begin
        m_wd++;
        if (m_wd >= MDT) m_to = 1;
      end else m_wd = 0;
      if (e_stD && m_scnt < CNT_SAT) m_scnt++;
      if (e_exc) m_busy = 0;
      else if (muldiv_startE && !e_stE && !e_flE) m_busy = 1;
      else if (muldiv_done) m_busy = 0;
    end
  endtask

  task automatic check_all();
    model_comb();
    chk("forwardaD", forwardaD, e_fwdaD);
    chk("forwardbD", forwardbD, e_fwdbD);
    chk("forwardaE", forwardaE, e_fwdaE);
    chk("forwardbE", forwardbE, e_fwdbE);
    chk("stallF", stallF, e_stF);
    chk("stallD", stallD, e_stD);
    chk("stallE", stallE, e_stE);
    chk("stallM", stallM, e_stM);
    chk("stallW", stallW, e_stW);
    chk("flushF", flushF, e_flF);
    chk("flushD", flushD, e_flD);
    chk("flushE", flushE, e_flE);
    chk("flushM", flushM, e_flM);
    chk("flushW", flushW, e_flW);
    chk("newpcF", newpcF, e_newpc);
    chk("muldiv_cancel", muldiv_cancel, e_cancel);
    chk("hilo_busy", hilo_busy, m_busy);
    chk("md_timeout", md_timeout, m_to);
    chk("stall_cnt", stall_cnt, m_scnt);
  endtask

  task automatic half_a();
    @(negedge clk);
    check_all();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    half_a();
    half_b();
  endtask

  task automatic clr();
    mem_stall = 0; rsD = 0; rtD = 0; branchD = 0; jrD = 0; hiloreadD = 0; muldivD = 0;
    rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0;
    muldiv_startE = 0; muldiv_done = 0; writeregM = 0; regwriteM = 0; memtoregM = 0;
    excepttypeM = 0; epcM = 0; writeregW = 0; regwriteW = 0;
  endtask

  logic [31:0] codes [11] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha,
                              32'hc, 32'hd, 32'he, 32'h3, 32'h20};

  initial begin
    #400000;
    $display("FAIL bench_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr();
    rst = 1;
    m_busy = 0; m_to = 0; m_wd = 0; m_scnt = 0;
    @(posedge clk); #1;
    half_a();
    chk("rst_busy", hilo_busy, 0);
    chk("rst_timeout", md_timeout, 0);
    chk("rst_cnt", stall_cnt, 0);
    half_b();
    rst = 0;

    // Load-use: lw r8 in E, add r8 in D.
    memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; rtD = 9;
    half_a();
    chk("t1_stallD", stallD, 1);
    chk("t1_flushE", flushE, 1);
    half_b();
    memtoregE = 0; regwriteE = 0; writeregE = 0;
    memtoregM = 1; regwriteM = 1; writeregM = 8;
    half_a();
    chk("t1_release", stallD, 0);
    half_b();
    clr();
    regwriteW = 1; writeregW = 8; rsE = 8; rtE = 9;
    half_a();
    chk("t1_fwdW", forwardaE, 2'b01);
    half_b();

    // Background divide; independent work flows, mfhi waits for done.
    clr();
    muldiv_startE = 1;
    half_a();
    chk("t2_busy_before", hilo_busy, 0);
    half_b();
    muldiv_startE = 0;
    for (int i = 0; i < 3; i++) begin
      rsD = AW'(3 + i); rtD = AW'(10 + i);
      half_a();
      chk("t2_busy", hilo_busy, 1);
      chk("t2_nostall", stallD, 0);
      half_b();
    end
    hiloreadD = 1;
    for (int i = 0; i < 3; i++) begin
      half_a();
      chk("t2_mfhi_wait", stallD, 1);
      half_b();
    end
    muldiv_done = 1;
    half_a();
    chk("t2_done_cycle", stallD, 1);
    half_b();
    muldiv_done = 0;
    half_a();
    chk("t2_idle", hilo_busy, 0);
    chk("t2_mfhi_go", stallD, 0);
    half_b();

    // Overflow exception while a divide is running.
    clr();
    muldiv_startE = 1;
    step();
    muldiv_startE = 0;
    excepttypeM = 32'hc;
    half_a();
    chk("t3_cancel", muldiv_cancel, 1);
    chk("t3_flushF", flushF, 1);
    chk("t3_flushW", flushW, 1);
    chk("t3_newpc", newpcF, 32'hbfc00380);
    half_b();
    clr();
    half_a();
    chk("t3_idle", hilo_busy, 0);
    half_b();

    // ERET held behind a memory wait.
    excepttypeM = 32'he; epcM = 32'h80001234; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      half_a();
      chk("t4_stallW", stallW, 1);
      chk("t4_noflush", flushF, 0);
      half_b();
    end
    mem_stall = 0;
    half_a();
    chk("t4_flushW", flushW, 1);
    chk("t4_newpc", newpcF, 32'h80001234);
    half_b();

    // Watchdog: stuck divide sets the sticky flag, only reset clears it.
    clr();
    muldiv_startE = 1;
    step();
    muldiv_startE = 0;
    for (int i = 0; i < 70; i++) begin
      half_a();
      if (i == 10) chk("t5_early", md_timeout, 0);
      half_b();
    end
    half_a();
    chk("t5_timeout", md_timeout, 1);
    half_b();
    muldiv_done = 1;
    step();
    muldiv_done = 0;
    half_a();
    chk("t5_sticky", md_timeout, 1);
    half_b();
    rst = 1;
    step();
    rst = 0;
    half_a();
    chk("t5_cleared", md_timeout, 0);
    half_b();

    // r0 never forwards; M beats W.
    clr();
    regwriteM = 1; regwriteW = 1;
    half_a();
    chk("t6_r0", forwardaE, 2'b00);
    half_b();
    rsE = 5; writeregM = 5; writeregW = 5;
    half_a();
    chk("t6_prio", forwardaE, 2'b10);
    half_b();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      mem_stall     = ($urandom_range(0, 5) == 0);
      rsD           = AW'($urandom_range(0, 7));
      rtD           = AW'($urandom_range(0, 7));
      rsE           = AW'($urandom_range(0, 7));
      rtE           = AW'($urandom_range(0, 7));
      writeregE     = AW'($urandom_range(0, 7));
      writeregM     = AW'($urandom_range(0, 7));
      writeregW     = AW'($urandom_range(0, 7));
      branchD       = ($urandom_range(0, 3) == 0);
      jrD           = ($urandom_range(0, 5) == 0);
      hiloreadD     = ($urandom_range(0, 4) == 0);
      muldivD       = ($urandom_range(0, 7) == 0);
      regwriteE     = ($urandom_range(0, 1) == 0);
      memtoregE     = ($urandom_range(0, 3) == 0);
      regwriteM     = ($urandom_range(0, 1) == 0);
      memtoregM     = ($urandom_range(0, 3) == 0);
      regwriteW     = ($urandom_range(0, 1) == 0);
      muldiv_done   = m_busy && ($urandom_range(0, 5) == 0);
      muldiv_startE = (!m_busy || muldiv_done) && ($urandom_range(0, 4) == 0);
      excepttypeM   = ($urandom_range(0, 9) == 0) ? codes[$urandom_range(0, 10)] : 32'h0;
      epcM          = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
